enrg_evt_merge: RTL

//  Downstream consumer of the two energy-digitizer event buffers.
//  On request from the event builder, it reads one event from each buffer and merges the two into one 12-bit word packet.
//  It controls each buffer's Send/SendErrBuf and forwards the buffer words unchanged.

---
 rtl/enrg_evt_merge_if.sv | 28 ++
 rtl/enrg_evt_merge.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/enrg_evt_merge_if.sv
// Energy event merger bus: digitizer-buffer control/data on one side,
// the merged event-builder word stream on the other.
interface enrg_evt_merge_if;
  logic        Go;
  logic        BufRdy0;
  logic        BufRdy1;
  logic [11:0] DataIn0;
  logic [11:0] DataIn1;
  logic [7:0]  ErrBuf0;
  logic [7:0]  ErrBuf1;
  logic        Send0;
  logic        Send1;
  logic        SendErrBuf;
  logic [11:0] DOut;
  logic        DValid;
  logic        DLast;
  logic        Busy;

  modport master (
    input  Go, BufRdy0, BufRdy1, DataIn0, DataIn1, ErrBuf0, ErrBuf1,
    output Send0, Send1, SendErrBuf, DOut, DValid, DLast, Busy
  );

  modport slave (
    output Go, BufRdy0, BufRdy1, DataIn0, DataIn1, ErrBuf0, ErrBuf1,
    input  Send0, Send1, SendErrBuf, DOut, DValid, DLast, Busy
  );
endinterface

// File: rtl/enrg_evt_merge.sv
// Merges one event from each energy-digitizer buffer into a single packet:
// header, board-0 count+data, board-1 count+data, trailer.
module enrg_evt_merge #(
  parameter int unsigned RD_LAT  = 2,    // must be >= 2
  parameter int unsigned GAP     = 2,    // must be >= 1
  parameter int unsigned TIMEOUT = 1023
) (
  input logic              Clock,
  input logic              Reset,
  enrg_evt_merge_if.master bus
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    RD_LOAD  = 8'(RD_LAT - 1);
  localparam logic [7:0]    GAP_LOAD = 8'(GAP);

  typedef enum logic [12:0] {
    IDLE  = 13'b0_0000_0000_0001,
    ERRQ  = 13'b0_0000_0000_0010,
    HDR   = 13'b0_0000_0000_0100,
    WAIT0 = 13'b0_0000_0000_1000,
    CNT0  = 13'b0_0000_0001_0000,
    DAT0  = 13'b0_0000_0010_0000,
    GAP0  = 13'b0_0000_0100_0000,
    SEND1 = 13'b0_0000_1000_0000,
    WAIT1 = 13'b0_0001_0000_0000,
    CNT1  = 13'b0_0010_0000_0000,
    DAT1  = 13'b0_0100_0000_0000,
    TRL   = 13'b0_1000_0000_0000,
    TOUT  = 13'b1_0000_0000_0000
  } state_t;

  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_cur;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    tot_q, tot_d;
  logic          fmt_q, fmt_d;
  logic          to_q, to_d;
  logic [8:0]    sum;
  logic          busy, go_acc;
  logic          send0, send1, send_err, dvalid, dlast;
  logic [11:0]   dout;
  logic          unused_err;

  assign busy       = pending_q || (state_q != IDLE);
  assign unused_err = ^{bus.ErrBuf0[7:2], bus.ErrBuf1[7:2]};

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    tot_d     = tot_q;
    fmt_d     = fmt_q;
    to_d      = to_q;
    send0     = 1'b0;
    send1     = 1'b0;
    send_err  = 1'b0;
    dout      = '0;
    dvalid    = 1'b0;
    dlast     = 1'b0;
    sum       = {1'b0, tot_q} + {1'b0, bus.DataIn1[7:0]};
    go_acc    = bus.Go && !busy;
    // A fresh Go is acted on in the same clock so the header lands two clocks later
    tmo_cur   = go_acc ? '0 : tmo_q;
    if (go_acc) begin
      pending_d = 1'b1;
      tmo_d     = '0;
    end
    case (state_q)
      IDLE: if (pending_q || go_acc) begin
        if (bus.BufRdy0 && bus.BufRdy1) begin
          state_d = ERRQ;
          to_d    = 1'b0;
          fmt_d   = 1'b0;
          tot_d   = '0;
        end else if (tmo_cur == TMO_LAST) begin
          state_d = TOUT;
          to_d    = 1'b1;
          fmt_d   = 1'b0;
          tot_d   = '0;
        end else begin
          tmo_d = tmo_cur + TW'(1);
        end
      end
      ERRQ: begin
        send_err = 1'b1;
        state_d  = HDR;
      end
      HDR: begin
        dout    = {4'hE, 2'b00, bus.ErrBuf0[1:0], bus.ErrBuf1[1:0], 2'b00};
        dvalid  = 1'b1;
        send0   = 1'b1;
        cnt_d   = RD_LOAD;
        state_d = WAIT0;
      end
      WAIT0: begin
        cnt_d   = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = CNT0;
      end
      CNT0: begin
        dout   = bus.DataIn0;
        dvalid = 1'b1;
        tot_d  = bus.DataIn0[7:0];
        if (bus.DataIn0[11:8] != 4'h0) fmt_d = 1'b1;
        if (bus.DataIn0[7:0] == 8'd0) begin
          cnt_d   = GAP_LOAD;
          state_d = GAP0;
        end else begin
          cnt_d   = bus.DataIn0[7:0];
          state_d = DAT0;
        end
      end
      DAT0: begin
        dout   = bus.DataIn0;
        dvalid = 1'b1;
        cnt_d  = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          cnt_d   = GAP_LOAD;
          state_d = GAP0;
        end
      end
      GAP0: begin
        cnt_d   = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = SEND1;
      end
      SEND1: begin
        send1   = 1'b1;
        cnt_d   = RD_LOAD;
        state_d = WAIT1;
      end
      WAIT1: begin
        cnt_d   = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = CNT1;
      end
      CNT1: begin
        dout   = bus.DataIn1;
        dvalid = 1'b1;
        tot_d  = sum[8] ? 8'hFF : sum[7:0];
        if (bus.DataIn1[11:8] != 4'h0) fmt_d = 1'b1;
        cnt_d  = bus.DataIn1[7:0];
        state_d = (bus.DataIn1[7:0] == 8'd0) ? TRL : DAT1;
      end
      DAT1: begin
        dout   = bus.DataIn1;
        dvalid = 1'b1;
        cnt_d  = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = TRL;
      end
      TRL: begin
        dout      = {1'b1, to_q, fmt_q, 1'b0, tot_q};
        dvalid    = 1'b1;
        dlast     = 1'b1;
        pending_d = 1'b0;
        state_d   = IDLE;
      end
      TOUT: begin
        dout    = 12'hE00;
        dvalid  = 1'b1;
        state_d = TRL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      tmo_q     <= '0;
      cnt_q     <= '0;
      tot_q     <= '0;
      fmt_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      tot_q     <= tot_d;
      fmt_q     <= fmt_d;
      to_q      <= to_d;
    end
  end

  assign bus.Send0      = send0;
  assign bus.Send1      = send1;
  assign bus.SendErrBuf = send_err;
  assign bus.DOut       = dout;
  assign bus.DValid     = dvalid;
  assign bus.DLast      = dlast;
  assign bus.Busy       = busy;

endmodule
